// File: rtl/udp_panel_reader_if.sv
// Request, panel read port and UDP sink bundle for udp_panel_reader.
// master = reader side, slave = requester / memory / UDP core side.
interface udp_panel_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_panel;
  logic [13:0] req_addr;
  logic [13:0] req_count;
  logic [31:0] req_ip;
  logic [15:0] req_port;
  logic [5:0]  rd_en;
  logic [15:0] rd_addr;
  logic [23:0] rd_data;
  logic        udp_sink_valid;
  logic        udp_sink_last;
  logic        udp_sink_ready;
  logic [15:0] udp_sink_src_port;
  logic [15:0] udp_sink_dst_port;
  logic [31:0] udp_sink_ip_address;
  logic [15:0] udp_sink_length;
  logic [31:0] udp_sink_data;
  logic        busy;

  modport master (
    input  req_valid, req_panel, req_addr, req_count,
    input  req_ip, req_port, rd_data, udp_sink_ready,
    output req_ready, rd_en, rd_addr,
    output udp_sink_valid, udp_sink_last,
    output udp_sink_src_port, udp_sink_dst_port,
    output udp_sink_ip_address, udp_sink_length,
    output udp_sink_data, busy
  );

  modport slave (
    output req_valid, req_panel, req_addr, req_count,
    output req_ip, req_port, rd_data, udp_sink_ready,
    input  req_ready, rd_en, rd_addr,
    input  udp_sink_valid, udp_sink_last,
    input  udp_sink_src_port, udp_sink_dst_port,
    input  udp_sink_ip_address, udp_sink_length,
    input  udp_sink_data, busy
  );
endinterface

// File: rtl/udp_panel_reader.sv
// Panel frame readback: fetches a pixel run and streams it as one UDP packet.
// Define UDP_PANEL_READER_HEADER_EN to prepend the 4-byte A5/panel/count header.
module udp_panel_reader #(
  parameter logic [15:0] PORT_MSB     = 16'h66,
  parameter int          MAX_PIXELS   = 256,
  parameter int          READ_LATENCY = 1
) (
  input logic                clock,
  input logic                reset,
  udp_panel_reader_if.master bus
);

`ifdef UDP_PANEL_READER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  localparam logic [13:0] MAXP = 14'(MAX_PIXELS);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [2:0]  panel_q, panel_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] port_q, port_d;
  logic [15:0] len_q, len_d;
  logic [13:0] rd_addr_q, rd_addr_d;
  logic [13:0] rd_left_q, rd_left_d;
  logic [13:0] wleft_q, wleft_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] nxt_q, nxt_d;
  logic        nxt_vld_q, nxt_vld_d;
  logic [1:0]  byte_q, byte_d;

  logic [READ_LATENCY-1:0]       pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][13:0] pipe_addr_q, pipe_addr_d;

  logic        accept, issue, cap_vld, hs, valid;
  logic [13:0] n_c;
  logic [31:0] cap_word;
  logic        unused_bits;

  assign accept  = bus.req_valid && rdy_q;
  assign n_c     = (bus.req_count > MAXP) ? MAXP : bus.req_count;
  assign valid   = (state_q == SEND);
  assign hs      = valid && bus.udp_sink_ready;
  assign cap_vld = pipe_vld_q[READ_LATENCY-1];
  assign cap_word = {pipe_addr_q[READ_LATENCY-1],
                     bus.rd_data[21:16],
                     bus.rd_data[13:8],
                     bus.rd_data[5:0]};

  // One read in flight or buffered at a time; the read
  // overlaps the four byte beats of the current word.
  assign issue = (state_q != IDLE) && (rd_left_q != 14'd0) &&
                 !(|pipe_vld_q) && !nxt_vld_q;

  assign unused_bits = ^{bus.rd_data[23:22],
                         bus.rd_data[15:14],
                         bus.rd_data[7:6]};

  always_comb begin
    state_d   = state_q;
    panel_d   = panel_q;
    ip_d      = ip_q;
    port_d    = port_q;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;
    rd_left_d = rd_left_q;
    wleft_d   = wleft_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    byte_d    = byte_q;

    pipe_vld_d[0]  = issue;
    pipe_addr_d[0] = rd_addr_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_addr_d[k] = pipe_addr_q[k-1];
    end

    if (issue) begin
      rd_addr_d = rd_addr_q + 14'd1;
      rd_left_d = rd_left_q - 14'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && bus.req_count != 14'd0 &&
            bus.req_panel <= 3'd5) begin
          panel_d   = bus.req_panel;
          ip_d      = bus.req_ip;
          port_d    = bus.req_port;
          len_d     = {n_c, 2'b00} + (HDR ? 16'd4 : 16'd0);
          rd_addr_d = bus.req_addr;
          rd_left_d = n_c;
          wleft_d   = n_c;
          nxt_vld_d = 1'b0;
          byte_d    = 2'd0;
          if (HDR) begin
            cur_d   = {8'hA5, 5'b0, bus.req_panel,
                       2'b0, n_c[13:8], n_c[7:0]};
            state_d = SEND;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (cap_vld) begin
          cur_d   = cap_word;
          wleft_d = wleft_q - 14'd1;
          byte_d  = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cap_vld) begin
          nxt_d     = cap_word;
          nxt_vld_d = 1'b1;
        end
        if (hs) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (wleft_q == 14'd0) begin
              state_d = IDLE;
            end else if (nxt_vld_q) begin
              cur_d     = nxt_q;
              nxt_vld_d = 1'b0;
              wleft_d   = wleft_q - 14'd1;
            end else if (cap_vld) begin
              cur_d     = cap_word;
              nxt_vld_d = 1'b0;
              wleft_d   = wleft_q - 14'd1;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      panel_q     <= '0;
      ip_q        <= '0;
      port_q      <= '0;
      len_q       <= '0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      wleft_q     <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      nxt_vld_q   <= 1'b0;
      byte_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      panel_q     <= panel_d;
      ip_q        <= ip_d;
      port_q      <= port_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      wleft_q     <= wleft_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      nxt_vld_q   <= nxt_vld_d;
      byte_q      <= byte_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_en     = issue ? 6'(6'd1 << panel_q) : 6'd0;
  assign bus.rd_addr   = issue ? {2'b00, rd_addr_q} : 16'd0;

  assign bus.udp_sink_valid = valid;
  assign bus.udp_sink_last  = valid && (byte_q == 2'd3) &&
                              (wleft_q == 14'd0);
  assign bus.udp_sink_data  = {24'h0, cur_q[{~byte_q, 3'b000} +: 8]};
  assign bus.udp_sink_src_port =
    (state_q != IDLE) ? {PORT_MSB[7:0], 5'b0, panel_q} : 16'h0;
  assign bus.udp_sink_dst_port   = port_q;
  assign bus.udp_sink_ip_address = ip_q;
  assign bus.udp_sink_length     = len_q;

endmodule

// File: tb/tb_udp_panel_reader.sv
// Directed bench for udp_panel_reader with a byte-level packet model.
module tb_udp_panel_reader;

`ifdef UDP_PANEL_READER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [23:0] pix = 24'h3F0015;
  bit rnd_rdy = 1'b0;

  udp_panel_reader_if bus();

  udp_panel_reader dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (|bus.rd_en) bus.rd_data <= pix;

  always @(posedge clock) begin
    #1;
    bus.udp_sink_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [15:0] exp_src, exp_dst, exp_len;
  logic [31:0] exp_ip;
  logic [5:0]  exp_en;
  logic [7:0]  got_b[$];
  bit          got_l[$];
  logic [15:0] rda[$];
  int rd_cnt = 0, vcnt = 0, bad_en = 0;
  int hdr_err = 0, hold_err = 0, last_cnt = 0;
  bit hold_pend = 1'b0, hold_l;
  logic [7:0] hold_d;

  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (|bus.rd_en) begin
        rd_cnt++;
        rda.push_back(bus.rd_addr);
        if (bus.rd_en != exp_en) bad_en++;
      end
      if (bus.udp_sink_valid) begin
        vcnt++;
        if (hold_pend && (bus.udp_sink_data[7:0] != hold_d ||
                          bus.udp_sink_last != hold_l)) hold_err++;
        if ({bus.udp_sink_src_port, bus.udp_sink_dst_port,
             bus.udp_sink_ip_address, bus.udp_sink_length} !==
            {exp_src, exp_dst, exp_ip, exp_len} ||
            bus.udp_sink_data[31:8] !== 24'h0) hdr_err++;
        hold_pend = !bus.udp_sink_ready;
        hold_d = bus.udp_sink_data[7:0];
        hold_l = bus.udp_sink_last;
        if (bus.udp_sink_ready) begin
          got_b.push_back(bus.udp_sink_data[7:0]);
          got_l.push_back(bus.udp_sink_last);
          if (bus.udp_sink_last) last_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_nz();
    return |{bus.req_ready, bus.busy, bus.rd_en, bus.rd_addr,
             bus.udp_sink_valid, bus.udp_sink_last,
             bus.udp_sink_src_port, bus.udp_sink_dst_port,
             bus.udp_sink_ip_address, bus.udp_sink_length,
             bus.udp_sink_data};
  endfunction

  int b0, r0, e0, h0, hl0, l0, v0;
  logic [13:0] nn;

  task automatic start(input logic [2:0] p, input logic [13:0] a,
                       input logic [13:0] c, input string tag);
    int k;
    b0 = got_b.size(); r0 = rd_cnt; e0 = bad_en; h0 = hdr_err;
    hl0 = hold_err; l0 = last_cnt; v0 = vcnt;
    nn = (c > 14'd256) ? 14'd256 : c;
    exp_src = {8'h66, 5'b0, p};
    exp_dst = 16'h1234;
    exp_ip  = 32'hC0A8_0001;
    exp_len = {nn, 2'b00} + (HDR ? 16'd4 : 16'd0);
    exp_en  = 6'(7'd1 << p);
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_panel = p;
    bus.req_addr  = a;
    bus.req_count = c;
    bus.req_port  = exp_dst;
    bus.req_ip    = exp_ip;
    k = 0;
    do begin @(negedge clock); #1; k++; end
    while (!bus.req_ready && k < 50);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (last_cnt == l0 && k < 3000) begin
      @(negedge clock); #1; k++;
    end
    chk({tag, "_done"}, 32'(last_cnt - l0), 1);
    @(negedge clock); #1;
    chk({tag, "_idle"}, {30'b0, bus.req_ready, bus.busy}, 32'h2);
  endtask

  task automatic check_pkt(input string tag, input logic [2:0] p,
                           input logic [13:0] addr);
    logic [7:0]  exp_b[$];
    logic [31:0] w;
    logic [13:0] a;
    int nb, mism;
    if (HDR) begin
      exp_b.push_back(8'hA5);
      exp_b.push_back({5'b0, p});
      exp_b.push_back({2'b0, nn[13:8]});
      exp_b.push_back(nn[7:0]);
    end
    for (int i = 0; i < int'(nn); i++) begin
      a = addr + 14'(i);
      w = {a, pix[21:16], pix[13:8], pix[5:0]};
      for (int j = 3; j >= 0; j--) exp_b.push_back(w[8*j +: 8]);
    end
    nb = got_b.size() - b0;
    chk({tag, "_nbytes"}, 32'(nb), 32'(exp_b.size()));
    mism = 0;
    for (int i = 0; i < nb && i < exp_b.size(); i++) begin
      if (got_b[b0+i] !== exp_b[i]) mism++;
      if (got_l[b0+i] != (i == exp_b.size() - 1)) mism++;
    end
    chk({tag, "_bytes"}, 32'(mism), 0);
    chk({tag, "_rdcnt"}, 32'(rd_cnt - r0), 32'(nn));
    chk({tag, "_rden"}, 32'(bad_en - e0), 0);
    chk({tag, "_hdr"}, 32'(hdr_err - h0), 0);
    chk({tag, "_hold"}, 32'(hold_err - hl0), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.req_valid = 1'b0;
    bus.req_panel = '0;
    bus.req_addr  = '0;
    bus.req_count = '0;
    bus.req_port  = '0;
    bus.req_ip    = '0;
    exp_src = '0; exp_dst = '0; exp_ip = '0; exp_len = '0; exp_en = '0;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_zero", 32'(outs_nz()), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    chk("rdy_lag", 32'(bus.req_ready), 0);
    @(negedge clock); #1;
    chk("rdy_up", 32'(bus.req_ready), 1);

    // T1: two pixels from panel 2
    start(3'd2, 14'h0010, 14'd2, "t1");
    wait_done("t1");
    check_pkt("t1", 3'd2, 14'h0010);
    if (rda.size() >= r0 + 2) begin
      chk("t1_addr0", 32'(rda[r0]), 32'h0010);
      chk("t1_addr1", 32'(rda[r0+1]), 32'h0011);
    end
    if (!HDR && got_b.size() >= b0 + 8) begin
      chk("t1_b1", 32'(got_b[b0+1]), 32'h43);
      chk("t1_b5", 32'(got_b[b0+5]), 32'h47);
    end

    // T2: address wrap
    pix = 24'h010203;
    start(3'd3, 14'h3FFF, 14'd2, "t2");
    wait_done("t2");
    check_pkt("t2", 3'd3, 14'h3FFF);
    if (rda.size() >= r0 + 2) begin
      chk("t2_addr0", 32'(rda[r0]), 32'h3FFF);
      chk("t2_addr1", 32'(rda[r0+1]), 32'h0000);
    end

    // T3: clipped count
    pix = 24'h2A1F05;
    start(3'd5, 14'h0100, 14'd1000, "t3");
    wait_done("t3");
    check_pkt("t3", 3'd5, 14'h0100);
    chk("t3_len", 32'(exp_len), HDR ? 32'd1028 : 32'd1024);

    // T4: T1 with random backpressure
    pix = 24'h3F0015;
    rnd_rdy = 1'b1;
    start(3'd2, 14'h0010, 14'd2, "t4");
    wait_done("t4");
    check_pkt("t4", 3'd2, 14'h0010);
    rnd_rdy = 1'b0;

    // T5: illegal panel, then zero count
    start(3'd6, 14'h0010, 14'd2, "t5a");
    @(negedge clock); #1;
    chk("t5a_ready", 32'(bus.req_ready), 1);
    repeat (4) @(negedge clock);
    #1;
    chk("t5a_rd", 32'(rd_cnt - r0), 0);
    chk("t5a_valid", 32'(vcnt - v0), 0);
    start(3'd1, 14'h0010, 14'd0, "t5b");
    @(negedge clock); #1;
    chk("t5b_ready", 32'(bus.req_ready), 1);
    repeat (4) @(negedge clock);
    #1;
    chk("t5b_rd", 32'(rd_cnt - r0), 0);
    chk("t5b_valid", 32'(vcnt - v0), 0);

    // T6: reset on byte 3, then a clean packet
    start(3'd2, 14'h0010, 14'd2, "t6");
    k = 0;
    while (got_b.size() - b0 < 2 && k < 100) begin
      @(negedge clock); #1; k++;
    end
    chk("t6_reach", 32'(got_b.size() - b0), 2);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("t6_zero", 32'(outs_nz()), 0);
    chk("t6_nolast", 32'(last_cnt - l0), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    start(3'd2, 14'h0010, 14'd2, "t6b");
    wait_done("t6b");
    check_pkt("t6b", 3'd2, 14'h0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
